posit_pio_bridge: RTL and testbench
===================================

POSIT_PIO_BRIDGE -- requirements
Module: posit_pio_bridge

Interface
REQ-001 SHALL have parameter WIDTH, default 32, posit operand/result width.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16, cycles operands must be unchanged before launch.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles in WAIT before abort.
REQ-004 Clock and reset: one clock, reset is asynchronous and active-high.
REQ-005 clock  in  1  sole clock, same domain as HPS PIO exports.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 num1  in  WIDTH  operand 1 from HPS PIO.
REQ-008 num2  in  WIDTH  operand 2 from HPS PIO.
REQ-009 result  out  WIDTH  last result, to HPS result PIO.
REQ-010 req_valid  out  1  request to posit arithmetic core.
REQ-011 req_ready  in  1  core accepts request.
REQ-012 req_num1, req_num2  out  WIDTH each  latched operands to core.
REQ-013 resp_valid  in  1  core result valid, single-cycle.
REQ-014 resp_result  in  WIDTH  core result.
REQ-015 busy  out  1  high in SETTLE, ISSUE, WAIT.
REQ-016 done  out  1  one-cycle pulse when result updates.
REQ-017 timeout_err  out  1  sticky abort flag.

Function
REQ-018 SHALL keep last_seen registers of {num1,num2}; change = inequality with last_seen in a cycle; last_seen updates every cycle.
REQ-019 States SHALL be IDLE, SETTLE, ISSUE, WAIT.
REQ-020 IDLE: change -> SETTLE, settle counter cleared.
REQ-021 SETTLE: change reloads counter to 0; counter reaching SETTLE_CYCLES-1 with no change -> ISSUE, capture num1/num2 into req_num1/req_num2 that cycle.
REQ-022 ISSUE: req_valid high, req_num1/req_num2 stable until req_ready sampled high; that cycle -> WAIT, timeout counter cleared.
REQ-023 WAIT: resp_valid -> result <= resp_result, done pulse next cycle, timeout_err cleared, -> IDLE.
REQ-024 WAIT: timeout counter reaching TIMEOUT_CYCLES-1 without resp_valid -> result <= NaR (MSB 1, rest 0), timeout_err set, done pulse, -> IDLE.
REQ-025 resp_valid and timeout expiry in same cycle: resp_valid wins.
REQ-026 Change during ISSUE/WAIT SHALL set pending flag; transaction completes unaltered; on completion go to SETTLE (not IDLE) and clear pending.
REQ-027 resp_valid outside WAIT SHALL be ignored.
REQ-028 Launch-to-request latency SHALL be exactly SETTLE_CYCLES cycles after last change.
REQ-029 result SHALL change only on REQ-023/REQ-024 events.

Reset
REQ-030 Reset SHALL force IDLE; result, req_num1, req_num2, last_seen = 0; req_valid, busy, done, timeout_err, pending = 0; counters = 0.
REQ-031 Reset mid-transaction SHALL drop req_valid immediately (asynchronous) and discard any in-flight response.
REQ-032 Operands equal to 0 after reset SHALL not launch an operation.

Structure
REQ-033 Package posit_bridge_pkg SHALL hold state enum, NaR constant function of WIDTH, and parameter defaults.
REQ-034 Settle counter with change detect SHALL be sub-module operand_settle_ctr (outputs change, settled); FSM, timeout and result registers stay in top.

Verification
REQ-035 num1=0x40000000, num2=0x40000000, core responds 0x48000000 after 5 cycles -> req_valid 16 cycles after change, result=0x48000000, done one pulse, busy low after.
REQ-036 num1 written, num2 written 5 cycles later -> exactly one request, req_num2 = new value, launch 16 cycles after second write.
REQ-037 req_ready held low 20 cycles -> req_valid and req_num* stable throughout, WAIT entered on first ready.
REQ-038 no resp_valid -> after 1024 WAIT cycles result=0x80000000, timeout_err=1; next good response clears timeout_err.
REQ-039 num1 changed during WAIT -> first result delivered, then SETTLE, second request with new num1.
REQ-040 reset asserted in WAIT, resp_valid arrives after release -> result stays 0, state IDLE, no done.

Source files
------------

// File: rtl/posit_bridge_pkg.sv
// posit_bridge_pkg: shared state encoding, parameter defaults and NaR constant for the posit PIO bridge
package posit_bridge_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, ISSUE, WAIT} state_t;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    function automatic logic [63:0] nar(input int w);
        return 64'd1 << (w - 1);
    endfunction
endpackage

// File: rtl/posit_pio_bridge_settle.sv
// operand_settle_ctr: flags operand changes against last_seen and counts quiet cycles while settling
module operand_settle_ctr
    import posit_bridge_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             run,
    output logic             change,
    output logic             settled
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    logic [2*WIDTH-1:0] last_seen;
    logic [CW-1:0] cnt;
    assign change = {num1, num2} != last_seen;
    assign settled = run && !change && cnt == CW'(SETTLE_CYCLES - 1);
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            last_seen <= '0;
            cnt <= '0;
        end else begin
            last_seen <= {num1, num2};
            cnt <= (run && !change && !settled) ? cnt + 1'b1 : '0;
        end
endmodule

// File: rtl/posit_pio_bridge.sv
// posit_pio_bridge: launches a posit operation once HPS PIO operands settle and returns the core result
module posit_pio_bridge
    import posit_bridge_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic [WIDTH-1:0] result,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [WIDTH-1:0] req_num1,
    output logic [WIDTH-1:0] req_num2,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_result,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WIDTH-1:0] NAR = WIDTH'(nar(WIDTH));
    state_t state;
    logic [TW-1:0] tcnt;
    logic pending, change, settled, expired, finish;
    operand_settle_ctr #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
        .clock(clock),
        .reset(reset),
        .num1(num1),
        .num2(num2),
        .run(state == SETTLE),
        .change(change),
        .settled(settled)
    );
    assign req_valid = state == ISSUE;
    assign busy = state != IDLE;
    assign expired = tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign finish = state == WAIT && (resp_valid || expired);
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            result <= '0;
            req_num1 <= '0;
            req_num2 <= '0;
            tcnt <= '0;
            pending <= 1'b0;
            done <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done <= finish;
            tcnt <= (state == WAIT) ? tcnt + 1'b1 : '0;
            // operand edits mid-transaction are remembered so the new operands get their own launch
            pending <= (state == ISSUE || state == WAIT) && !finish && (pending || change);
            if (finish) begin
                result <= resp_valid ? resp_result : NAR;
                timeout_err <= !resp_valid;
            end
            if (settled) begin
                req_num1 <= num1;
                req_num2 <= num2;
            end
            case (state)
                IDLE:    if (change) state <= SETTLE;
                SETTLE:  if (settled) state <= ISSUE;
                ISSUE:   if (req_ready) state <= WAIT;
                WAIT:    if (finish) state <= (pending || change) ? SETTLE : IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_posit_pio_bridge.sv
// tb_posit_pio_bridge: randomized transaction-level checks of the posit PIO bridge against a scoreboard model
module tb_posit_pio_bridge;
    localparam int W = 32;
    localparam int S = 16;
    localparam int T = 1024;
    localparam logic [W-1:0] NAR = 32'h8000_0000;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] num1 = '0, num2 = '0, resp_result = '0;
    logic [W-1:0] result, req_num1, req_num2;
    logic req_valid, busy, done, timeout_err;
    logic req_ready = 1'b0, resp_valid = 1'b0;
    logic [W-1:0] exp_result = '0;
    logic exp_terr = 1'b0;
    int n_cmp = 0, n_bad = 0;

    always #5 clock = ~clock;

    posit_pio_bridge #(.WIDTH(W), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock),
        .reset(reset),
        .num1(num1),
        .num2(num2),
        .result(result),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_num1(req_num1),
        .req_num2(req_num2),
        .resp_valid(resp_valid),
        .resp_result(resp_result),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        num1 = a;
        num2 = b;
    endtask

    // counts negedges from the current one until req_valid is seen
    task automatic wait_launch(output int k);
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!req_valid && k < 200);
    endtask

    task automatic handshake(input int rdly, input logic [W-1:0] ea, input logic [W-1:0] eb);
        logic stable = 1'b1;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clock);
            if (!req_valid || req_num1 !== ea || req_num2 !== eb) stable = 1'b0;
        end
        if (rdly > 0) check("req_hold", stable, 1);
        req_ready = 1'b1;
        @(negedge clock);
        req_ready = 1'b0;
        check("wait_entered", req_valid, 0);
        check("busy_wait", busy, 1);
    endtask

    task automatic respond(input int pdly, input logic [W-1:0] r);
        repeat (pdly) @(negedge clock);
        resp_valid = 1'b1;
        resp_result = r;
        @(negedge clock);
        resp_valid = 1'b0;
        resp_result = ~r;
        exp_result = r;
        exp_terr = 1'b0;
        check("done_pulse", done, 1);
        check("result", result, exp_result);
        check("timeout_err", timeout_err, exp_terr);
    endtask

    // one launch: optional second write to num2 after gap cycles, then ready/response delays
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int gap,
                           input logic [W-1:0] b2, input int rdly, input int pdly, input logic [W-1:0] r);
        int k;
        logic early = 1'b0;
        logic [W-1:0] eb;
        eb = b;
        write_ops(a, b);
        if (gap > 0) begin
            repeat (gap) begin
                @(negedge clock);
                early |= req_valid;
            end
            num2 = b2;
            eb = b2;
            check("no_early_req", early, 0);
        end
        wait_launch(k);
        check("latency", k, S + 1);
        check("req_num1", req_num1, a);
        check("req_num2", req_num2, eb);
        check("result_held", result, exp_result);
        handshake(rdly, a, eb);
        respond(pdly, r);
        @(negedge clock);
        check("done_single", done, 0);
        check("idle_busy", busy, 0);
        resp_valid = 1'b1;
        resp_result = $urandom;
        @(negedge clock);
        resp_valid = 1'b0;
        check("stray_result", result, exp_result);
        check("stray_done", done, 0);
        check("stray_busy", busy, 0);
    endtask

    initial begin
        int k;
        logic quiet;
        logic [W-1:0] a, b;
        repeat (3) @(negedge clock);
        check("rst_result", result, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_req_num1", req_num1, 0);
        check("rst_req_num2", req_num2, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_terr", timeout_err, 0);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (30) begin
            @(negedge clock);
            if (busy || req_valid) quiet = 1'b0;
        end
        check("zero_no_launch", quiet, 1);

        run_txn(32'h4000_0000, 32'h4000_0000, 0, '0, 0, 5, 32'h4800_0000);
        run_txn(32'h3800_0000, 32'h1234_5678, 5, 32'h5000_0000, 1, 3, 32'h4C00_0000);
        run_txn(32'h2222_0000, 32'h4444_0000, 0, '0, 20, 2, 32'h6000_0000);

        write_ops(32'h7000_0001, 32'h0F0F_0F0F);
        wait_launch(k);
        check("to_latency", k, S + 1);
        handshake(0, 32'h7000_0001, 32'h0F0F_0F0F);
        k = 0;
        while (!done && k < T + 50) begin
            @(negedge clock);
            k++;
        end
        exp_result = NAR;
        exp_terr = 1'b1;
        check("to_cycles", k, T);
        check("to_result", result, exp_result);
        check("to_flag", timeout_err, exp_terr);
        @(negedge clock);
        check("to_done_single", done, 0);
        check("to_flag_sticky", timeout_err, 1);
        run_txn(32'h1111_1111, 32'h2222_2222, 0, '0, 0, 4, 32'h3333_3333);

        write_ops(32'h4100_0000, 32'h4200_0000);
        wait_launch(k);
        handshake(2, 32'h4100_0000, 32'h4200_0000);
        repeat (3) @(negedge clock);
        num1 = 32'h5100_0000;
        respond(4, 32'hABCD_0000);
        check("pend_busy", busy, 1);
        wait_launch(k);
        check("pend_latency", k, S);
        check("pend_req_num1", req_num1, 32'h5100_0000);
        check("pend_req_num2", req_num2, 32'h4200_0000);
        handshake(0, 32'h5100_0000, 32'h4200_0000);
        respond(1, 32'hDCBA_0000);
        @(negedge clock);
        check("pend_idle", busy, 0);

        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom;
            if ({a, b} == {num1, num2}) a = ~a;
            run_txn(a, b, $urandom_range(0, S - 1), b ^ ($urandom | 32'd1),
                    $urandom_range(0, 25), $urandom_range(0, 40), $urandom);
        end

        write_ops(32'h4400_0000, 32'h4600_0000);
        wait_launch(k);
        handshake(0, 32'h4400_0000, 32'h4600_0000);
        @(negedge clock);
        #2;
        reset = 1'b1;
        num1 = '0;
        num2 = '0;
        #1;
        check("arst_req_valid", req_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_result", result, 0);
        @(negedge clock);
        reset = 1'b0;
        resp_valid = 1'b1;
        resp_result = 32'h7777_7777;
        @(negedge clock);
        resp_valid = 1'b0;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (done || busy || result != '0) quiet = 1'b0;
        end
        check("arst_discard", quiet, 1);
        check("arst_final_result", result, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
